// File: rtl/dmem_arbiter_if.sv
// Single-master access bus for dmem_arbiter: request/beat handshake plus data.
// The master modport is the requester side; the slave modport is the arbiter side.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: registered ownership, round-robin or fixed priority,
// bounded locked bursts. Optional stall counter when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned LOCK_MAX      = 8
) (
  input  logic          sysclk,
  input  logic          reset,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [31:0]   mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  input  logic          perf_clr,
  output logic [15:0]   stall_cnt
`endif
);

  localparam logic [7:0] LockLast = 8'(LOCK_MAX - 1);

  typedef enum logic [1:0] {OwnNone, OwnM0, OwnM1} owner_e;

  owner_e     owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] beat_q, beat_d;
  logic       active0, active1;
  logic       keep_lock;

  assign active0 = (owner_q == OwnM0) & m0.req;
  assign active1 = (owner_q == OwnM1) & m1.req;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      owner_q <= OwnNone;
      last_q  <= 1'b1;
      beat_q  <= 8'd0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    owner_d   = owner_q;
    beat_d    = beat_q;
    last_d    = last_q;
    keep_lock = 1'b0;
    if (active0) begin
      last_d = 1'b0;
    end else if (active1) begin
      last_d = 1'b1;
    end
    keep_lock = (active0 & m0.lock & ((beat_q < LockLast) | ~m1.req)) |
                (active1 & m1.lock & ((beat_q < LockLast) | ~m0.req));
    // The tie-break uses last_d so the beat finishing now counts as served.
    if (keep_lock) begin
      owner_d = owner_q;
    end else if (!m0.req && !m1.req) begin
      owner_d = OwnNone;
    end else if (m0.req && !m1.req) begin
      owner_d = OwnM0;
    end else if (!m0.req && m1.req) begin
      owner_d = OwnM1;
    end else if (PRIORITY_MODE != 0) begin
      owner_d = OwnM0;
    end else begin
      owner_d = last_d ? OwnM0 : OwnM1;
    end
    if (keep_lock) begin
      beat_d = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
    end else if ((owner_d != owner_q) || (active0 & ~m0.lock) || (active1 & ~m1.lock)) begin
      beat_d = 8'd0;
    end
  end

  always_comb begin
    m0.ack    = active0;
    m1.ack    = active1;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (active0) begin
      mem_addr  = m0.addr;
      mem_wdata = m0.wdata;
      mem_write = m0.we;
      mem_read  = ~m0.we;
    end else if (active1) begin
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
      mem_write = m1.we;
      mem_read  = ~m1.we;
    end
  end

  assign m0.rdata = mem_rdata;
  assign m1.rdata = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic stall;
  assign stall = (m0.req & ~active0) | (m1.req & ~active1);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (perf_clr) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
